// File: rtl/mux_select_scanner_if.sv
// Handshake and mux-facing signals of the 4-to-1 mux select scanner.
// master = controlling logic plus the mux itself, slave = the scanner.
interface mux_select_scanner_if;
    logic       start;
    logic       abort;
    logic [3:0] chan_mask;
    logic       q_in;
    logic       s1;
    logic       s0;
    logic       busy;
    logic       sample_valid;
    logic [1:0] sample_idx;
    logic [3:0] snapshot;
    logic       scan_done;

    modport master (
        output start, abort, chan_mask, q_in,
        input  s1, s0, busy, sample_valid, sample_idx, snapshot, scan_done
    );

    modport slave (
        input  start, abort, chan_mask, q_in,
        output s1, s0, busy, sample_valid, sample_idx, snapshot, scan_done
    );
endinterface

// File: rtl/mux_select_scanner.sv
// Steps the mux selects through the enabled channels, holding each for DWELL cycles and sampling Q.
// Optional macro CONTINUOUS_SCAN_EN: wrap back to the lowest channel after each pass instead of idling.
module mux_select_scanner #(
    parameter int DWELL = 4,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    mux_select_scanner_if.slave  bus
);

    typedef enum logic {IDLE, SCAN} state_t;

    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DWELL - 1);

    function automatic logic [1:0] lowest_chan(input logic [3:0] m);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (m[i]) idx = 2'(i);
        end
        return idx;
    endfunction

    // Returns {found, idx} of the lowest enabled channel strictly above cur.
    function automatic logic [2:0] next_chan(input logic [3:0] m, input logic [1:0] cur);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 3; i >= 0; i--) begin
            if (m[i] && (2'(i) > cur)) r = {1'b1, 2'(i)};
        end
        return r;
    endfunction

    state_t           state_q, state_d;
    logic [1:0]       sel_q, sel_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       mask_q, mask_d;
    logic [3:0]       snapshot_q, snapshot_d;
    logic [1:0]       sample_idx_q, sample_idx_d;
    logic             sample_valid_q, sample_valid_d;
    logic             scan_done_q, scan_done_d;
    logic             busy_q, busy_d;
    logic [2:0]       nxt;

    always_comb begin
        state_d        = state_q;
        sel_d          = sel_q;
        cnt_d          = cnt_q;
        mask_d         = mask_q;
        snapshot_d     = snapshot_q;
        sample_idx_d   = sample_idx_q;
        sample_valid_d = 1'b0;
        scan_done_d    = 1'b0;
        busy_d         = busy_q;
        nxt            = next_chan(mask_q, sel_q);

        case (state_q)
            IDLE: begin
                if (bus.start && !bus.abort && (bus.chan_mask != 4'd0)) begin
                    state_d    = SCAN;
                    mask_d     = bus.chan_mask;
                    snapshot_d = 4'd0;
                    sel_d      = lowest_chan(bus.chan_mask);
                    cnt_d      = RELOAD;
                    busy_d     = 1'b1;
                end
            end
            SCAN: begin
                if (bus.abort) begin
                    state_d = IDLE;
                    sel_d   = 2'd0;
                    busy_d  = 1'b0;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    snapshot_d[sel_q] = bus.q_in;
                    sample_idx_d      = sel_q;
                    sample_valid_d    = 1'b1;
                    if (nxt[2]) begin
                        sel_d = nxt[1:0];
                        cnt_d = RELOAD;
                    end else begin
                        scan_done_d = 1'b1;
`ifdef CONTINUOUS_SCAN_EN
                        sel_d = lowest_chan(mask_q);
                        cnt_d = RELOAD;
`else
                        state_d = IDLE;
                        sel_d   = 2'd0;
                        busy_d  = 1'b0;
`endif
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            sel_q          <= 2'd0;
            cnt_q          <= '0;
            mask_q         <= 4'd0;
            snapshot_q     <= 4'd0;
            sample_idx_q   <= 2'd0;
            sample_valid_q <= 1'b0;
            scan_done_q    <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            sel_q          <= sel_d;
            cnt_q          <= cnt_d;
            mask_q         <= mask_d;
            snapshot_q     <= snapshot_d;
            sample_idx_q   <= sample_idx_d;
            sample_valid_q <= sample_valid_d;
            scan_done_q    <= scan_done_d;
            busy_q         <= busy_d;
        end
    end

    assign bus.s1           = sel_q[1];
    assign bus.s0           = sel_q[0];
    assign bus.busy         = busy_q;
    assign bus.sample_valid = sample_valid_q;
    assign bus.sample_idx   = sample_idx_q;
    assign bus.snapshot     = snapshot_q;
    assign bus.scan_done    = scan_done_q;

endmodule
